muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It handles full-width unsigned/signed multiply and unsigned/signed divide, which the ALU does not (the ALU only has a 16x16 multiply and no divide). It uses a start/busy/done handshake so the sequencer can stall on it. The datapath is radix-2 with one bit per cycle and produces a 2*WIDTH product or a quotient/remainder pair, plus flags.

---
 rtl/muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit with a start/busy/done handshake.
// Operations: MULU, MULS (2*WIDTH product), DIVU, DIVS (quotient/remainder).
// Optional build macro MULDIV_EARLY_OUT_EN: trivial multiplies and divides whose
// quotient is obviously zero finish in 2 cycles instead of WIDTH+2.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero_out,
    output logic             neg_out,
    output logic             div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [1:0] OP_MULS = 2'd1;
    localparam logic [1:0] OP_DIVS = 2'd3;

    logic [1:0]       state_reg;
    logic [1:0]       op_reg;
    logic             neg_a_reg;
    logic             neg_b_reg;
    logic             dz_reg;
    logic [CNT_W-1:0] cnt_reg;
    // hi_reg/lo_reg: product accumulator for multiply, remainder/quotient for divide.
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    // opnd_reg: multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0] opnd_reg;
    logic             done_reg;
    logic [WIDTH-1:0] result_lo_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             zero_reg;
    logic             neg_reg;
    logic             div_by_zero_reg;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    // Operand conditioning at accept: signed ops work on magnitudes (MIN maps to 2^(WIDTH-1)).
    always_comb begin
        sign_a = op[0] & a[WIDTH-1];
        sign_b = op[0] & b[WIDTH-1];
        mag_a  = sign_a ? (~a + 1'b1) : a;
        mag_b  = sign_b ? (~b + 1'b1) : b;
    end

    // One iteration: shift-and-add (multiplier LSB in lo_reg[0]) or restoring-divide step.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + {1'b0, {WIDTH{lo_reg[0]}} & opnd_reg};
        div_trial = {hi_reg, lo_reg[WIDTH-1]} - {1'b0, opnd_reg};
        step_hi   = hi_reg;
        step_lo   = lo_reg;
        if (op_reg[1]) begin
            if (div_trial[WIDTH]) begin
                step_hi = {hi_reg[WIDTH-2:0], lo_reg[WIDTH-1]};
                step_lo = {lo_reg[WIDTH-2:0], 1'b0};
            end else begin
                step_hi = div_trial[WIDTH-1:0];
                step_lo = {lo_reg[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    // Sign fix-up of the unsigned core result; divide-by-zero results pass through untouched.
    always_comb begin
        fix_prod = {hi_reg, lo_reg};
        fix_quo  = lo_reg;
        fix_rem  = hi_reg;
        if (op_reg == OP_MULS && (neg_a_reg ^ neg_b_reg))
            fix_prod = ~{hi_reg, lo_reg} + 1'b1;
        if (op_reg == OP_DIVS && !dz_reg) begin
            if (neg_a_reg ^ neg_b_reg)
                fix_quo = ~lo_reg + 1'b1;
            if (neg_a_reg)
                fix_rem = ~hi_reg + 1'b1;
        end
    end

    // Control FSM, datapath registers and result/flag registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            op_reg          <= '0;
            neg_a_reg       <= 1'b0;
            neg_b_reg       <= 1'b0;
            dz_reg          <= 1'b0;
            cnt_reg         <= '0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            opnd_reg        <= '0;
            done_reg        <= 1'b0;
            result_lo_reg   <= '0;
            result_hi_reg   <= '0;
            zero_reg        <= 1'b0;
            neg_reg         <= 1'b0;
            div_by_zero_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        op_reg    <= op;
                        neg_a_reg <= sign_a;
                        neg_b_reg <= sign_b;
                        dz_reg    <= 1'b0;
                        cnt_reg   <= CNT_W'(WIDTH);
                        hi_reg    <= '0;
                        state_reg <= S_RUN;
                        if (op[1]) begin
                            lo_reg   <= mag_a;
                            opnd_reg <= mag_b;
                        end else begin
                            lo_reg   <= mag_b;
                            opnd_reg <= mag_a;
                        end
                        if (op[1] && b == '0) begin
                            dz_reg    <= 1'b1;
                            hi_reg    <= a;
                            lo_reg    <= '1;
                            state_reg <= S_FIX;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (!op[1] && (a == '0 || b == '0)) begin
                            lo_reg    <= '0;
                            state_reg <= S_FIX;
                        end else if (op[1] && mag_a < mag_b) begin
                            hi_reg    <= mag_a;
                            lo_reg    <= '0;
                            state_reg <= S_FIX;
                        end
`endif
                    end
                end
                S_RUN: begin
                    hi_reg  <= step_hi;
                    lo_reg  <= step_lo;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1))
                        state_reg <= S_FIX;
                end
                S_FIX: begin
                    if (op_reg[1]) begin
                        result_lo_reg <= fix_quo;
                        result_hi_reg <= fix_rem;
                        zero_reg      <= (fix_quo == '0);
                        neg_reg       <= fix_quo[WIDTH-1];
                    end else begin
                        result_lo_reg <= fix_prod[WIDTH-1:0];
                        result_hi_reg <= fix_prod[2*WIDTH-1:WIDTH];
                        zero_reg      <= (fix_prod == '0);
                        neg_reg       <= fix_prod[2*WIDTH-1];
                    end
                    div_by_zero_reg <= dz_reg;
                    done_reg        <= 1'b1;
                    state_reg       <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_reg != S_IDLE);
    assign done        = done_reg;
    assign result_lo   = result_lo_reg;
    assign result_hi   = result_hi_reg;
    assign zero_out    = zero_reg;
    assign neg_out     = neg_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit (WIDTH=32) against an
// arithmetic reference model built on 64-bit integer multiply/divide.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [1:0] MULU = 2'd0, MULS = 2'd1, DIVU = 2'd2, DIVS = 2'd3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   op = '0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zero_out, neg_out, div_by_zero;
    logic [W-1:0] result_lo, result_hi;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .op(op), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
        .zero_out(zero_out), .neg_out(neg_out), .div_by_zero(div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, truncating signed division.
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic z, output logic n, output logic dz, output int lat);
        longint sx, sy, q, r, ax, ay;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        dz = 1'b0;
        lat = W + 2;
        if (!o[1]) begin
            if (o == MULU) p = {32'b0, x} * {32'b0, y};
            else           p = sx * sy;
            lo = p[31:0];
            hi = p[63:32];
            z = (p == 64'd0);
            n = p[63];
`ifdef MULDIV_EARLY_OUT_EN
            if (x == 0 || y == 0) lat = 2;
`endif
        end else begin
            if (y == 0) begin
                lo = '1;
                hi = x;
                dz = 1'b1;
                lat = 2;
            end else begin
                if (o == DIVU) begin
                    ax = longint'({32'b0, x});
                    ay = longint'({32'b0, y});
                    q = ax / ay;
                    r = ax % ay;
                end else begin
                    ax = (sx < 0) ? -sx : sx;
                    ay = (sy < 0) ? -sy : sy;
                    q = sx / sy;
                    r = sx % sy;
                end
                lo = q[31:0];
                hi = r[31:0];
`ifdef MULDIV_EARLY_OUT_EN
                if (ax < ay) lat = 2;
`endif
            end
            z = (lo == 0);
            n = lo[W-1];
        end
    endtask

    // Issue one operation from the current (post-edge) time and check it at done.
    // With hold=1, start stays high and a/b are scrambled while busy; the caller must
    // drive the next request (or drop start) on return.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit hold);
        logic [W-1:0] e_lo, e_hi;
        logic e_z, e_n, e_dz;
        int e_lat, lat, bsy;
        bit got;
        model(o, x, y, e_lo, e_hi, e_z, e_n, e_dz, e_lat);
        op = o; a = x; b = y; start = 1'b1;
        lat = 0; bsy = 0; got = 0;
        while (!got && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (hold) begin
                a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) got = 1;
            else if (busy) bsy++;
        end
        check("done_seen", 64'(got), 64'd1);
        if (got) begin
            check("latency", 64'(lat), 64'(e_lat));
            check("busy_cycles", 64'(bsy), 64'(e_lat - 1));
            check("busy_at_done", 64'(busy), 64'd0);
            check("result_lo", 64'(result_lo), 64'(e_lo));
            check("result_hi", 64'(result_hi), 64'(e_hi));
            check("zero_out", 64'(zero_out), 64'(e_z));
            check("neg_out", 64'(neg_out), 64'(e_n));
            check("div_by_zero", 64'(div_by_zero), 64'(e_dz));
        end
        $display("op=%0d a=%h b=%h -> lo=%h hi=%h z=%0d n=%0d dz=%0d lat=%0d",
                 o, x, y, result_lo, result_hi, zero_out, neg_out, div_by_zero, lat);
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] specials [4];
        specials[0] = 32'h0;
        specials[1] = 32'h1;
        specials[2] = 32'hFFFFFFFF;
        specials[3] = 32'h80000000;
        case ($urandom_range(0, 3))
            0: return specials[$urandom_range(0, 3)];
            1: return W'($urandom_range(0, 20));
            2: return W'($urandom_range(0, 20)) - W'(10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int extra_done;
        // Reset state.
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_lo", 64'(result_lo), 64'd0);
        check("rst_hi", 64'(result_hi), 64'd0);
        check("rst_zero", 64'(zero_out), 64'd0);
        check("rst_neg", 64'(neg_out), 64'd0);
        check("rst_dz", 64'(div_by_zero), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed cases.
        run_op(MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op(MULS, 32'hFFFFFFFD, 32'd7, 0);
        run_op(DIVS, 32'hFFFFFFF9, 32'd2, 0);
        run_op(DIVS, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(DIVU, 32'd100, 32'd0, 0);
        run_op(DIVU, 32'd100, 32'd7, 0);
        run_op(MULU, 32'd5, 32'd0, 0);
        run_op(DIVU, 32'd3, 32'd9, 0);
        run_op(DIVS, 32'h7, 32'hFFFFFFFE, 0);

        // Back-to-back: start held through busy, next op accepted in the done cycle.
        run_op(MULU, 32'd6, 32'd7, 1);
        run_op(DIVU, 32'd42, 32'd6, 0);

        // Results hold after done.
        repeat (3) @(posedge clock);
        #1;
        check("hold_lo", 64'(result_lo), 64'd7);
        check("hold_done", 64'(done), 64'd0);

        // Reset mid-operation aborts with no done pulse.
        op = MULU; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_lo", 64'(result_lo), 64'd0);
        check("abort_hi", 64'(result_hi), 64'd0);
        check("abort_flags", 64'({zero_out, neg_out, div_by_zero}), 64'd0);
        extra_done = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (done) extra_done++;
        end
        check("abort_no_done", 64'(extra_done), 64'd0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
